alarm_trigger: RTL and testbench
================================

ALARM_TRIGGER -- requirements
Module: alarm_trigger

Interface
REQ-001 Parameter RING_TICKS, default 600, sets the ring timeout in clk10hz ticks (60 s).
REQ-002 Parameter SNOOZE_TICKS, default 3000, sets the snooze interval in ticks (5 min).
REQ-003 Parameter MAX_SNOOZE, default 3, sets the maximum snoozes per alarm event (range 0..3).
REQ-004 Port clk10hz, input, 1 bit, is the single 10 Hz system clock; all state updates occur on its rising edge.
REQ-005 Port nReset, input, 1 bit, is the reset: asynchronous and active-low.
REQ-006 Ports alarmHourTens, alarmHourMu, alarmMinTens, alarmMinMu, inputs, 4 bits each, are the BCD alarm time from the alarm-setting stage.
REQ-007 Ports timeHourTens, timeHourMu, timeMinTens, timeMinMu, timeSecTens, timeSecMu, inputs, 4 bits each, are the BCD current time.
REQ-008 Port alarmEn, input, 1 bit, is the alarm enable level (1 = armed).
REQ-009 Port snoozeBtn, input, 1 bit, is the snooze button, already debounced and synchronous to clk10hz.
REQ-010 Port stopBtn, input, 1 bit, is the stop button, already debounced and synchronous to clk10hz.
REQ-011 Port buzzer, output, 1 bit, drives the sounder.
REQ-012 Port ringing, output, 1 bit, is 1 while the state is RING.
REQ-013 Port snoozing, output, 1 bit, is 1 while the state is SNOOZE.
REQ-014 Port snoozesLeft, output, 2 bits, is MAX_SNOOZE minus the snoozes used in the current event.

Function
REQ-015 match SHALL be 1 when all four hour/minute time digits equal the corresponding alarm digits AND timeSecTens = 0 AND timeSecMu = 0.
REQ-016 The block SHALL register matchPrev, snzPrev and stopPrev each cycle.
REQ-017 Edge detects SHALL be matchRise = match & !matchPrev, snzRise = snoozeBtn & !snzPrev and stopRise = stopBtn & !stopPrev.
REQ-018 The state machine SHALL have three states, encoded IDLE = 00, RING = 01, SNOOZE = 10; code 11 SHALL go to IDLE on the next edge.
REQ-019 From IDLE, alarmEn & matchRise SHALL cause entry to RING at that edge, with ringCnt = 0 and snoozesLeft = MAX_SNOOZE; otherwise the state SHALL stay IDLE.
REQ-020 In RING, transitions SHALL be evaluated in this priority order: !alarmEn -> IDLE; stopRise -> IDLE; snzRise & snoozesLeft > 0 -> SNOOZE (snoozesLeft decrements, snzCnt = 0); ringCnt = RING_TICKS-1 -> IDLE (timeout); otherwise ringCnt increments.
REQ-021 In RING, snzRise with snoozesLeft = 0 SHALL be ignored, and ringing SHALL continue.
REQ-022 In SNOOZE, transitions SHALL be evaluated in this priority order: !alarmEn -> IDLE; stopRise -> IDLE; snzCnt = SNOOZE_TICKS-1 -> RING (ringCnt = 0); otherwise snzCnt increments.
REQ-023 In SNOOZE, snzRise SHALL be ignored.
REQ-024 matchRise SHALL be ignored in both RING and SNOOZE.
REQ-025 buzzer SHALL be 1 exactly when state = RING and (ringCnt mod 10) < 5, giving a 1 Hz beep with 50 % duty.
REQ-026 The beep pattern SHALL restart on every entry to RING, so buzzer = 1 in the first RING cycle.
REQ-027 Latency from the first cycle in which match = 1 to ringing = 1 SHALL be one clock edge.
REQ-028 Latency from stopRise or snzRise to the state change SHALL be one clock edge.
REQ-029 Counter widths SHALL be at least ceil(log2(parameter)); counters SHALL never exceed parameter-1.
REQ-030 Returning to IDLE SHALL clear ringCnt and snzCnt.
REQ-031 snoozesLeft SHALL hold its value in IDLE until the next alarm event.
REQ-032 A match that is still high when the state returns to IDLE SHALL NOT retrigger, since matchPrev = 1.
REQ-033 A button held across entry to a state SHALL NOT act until it is released and pressed again.

Reset
REQ-034 While nReset = 0, the state SHALL be IDLE, ringCnt and snzCnt SHALL be 0, matchPrev, snzPrev and stopPrev SHALL be 0, and snoozesLeft SHALL be MAX_SNOOZE.
REQ-035 While nReset = 0, buzzer = 0, ringing = 0 and snoozing = 0.
REQ-036 Assertion of nReset SHALL take effect immediately, independent of clk10hz, including mid-RING and mid-SNOOZE.
REQ-037 After nReset is released, a match already high in the first cycle SHALL count as a rise and SHALL start ringing if alarmEn = 1.

Verification
REQ-038 Scenario: alarm 07:30, time steps 07:29:59 -> 07:30:00 with alarmEn = 1 -> ringing = 1 after one edge, buzzer = 1 for ticks 0-4 and 0 for ticks 5-9, snoozesLeft = 3.
REQ-039 Scenario: ringing with no buttons pressed -> ringing drops to 0 exactly 600 ticks after entry, and state = IDLE.
REQ-040 Scenario: four snoozeBtn pulses, one per RING period, with SNOOZE_TICKS = 20 for simulation -> snoozesLeft goes 3, 2, 1, 0; the 4th pulse is ignored and ringing stays 1; each SNOOZE lasts exactly 20 ticks before RING.
REQ-041 Scenario: stopBtn pressed in the same cycle as snoozeBtn during RING -> state = IDLE and snoozing never 1.
REQ-042 Scenario: alarmEn = 0 at 07:30:00 -> no ringing; alarmEn raised at 07:30:00 while match is still high -> no ringing (matchPrev = 1).
REQ-043 Scenario: nReset pulsed low mid-SNOOZE between clock edges -> outputs reach 0 and snoozesLeft = 3 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/alarm_trigger.sv
// rtl/alarm_trigger.sv - alarm clock trigger: match detect, ring/snooze FSM, beep generator
module alarm_trigger #(
    parameter int RING_TICKS   = 600,
    parameter int SNOOZE_TICKS = 3000,
    parameter int MAX_SNOOZE   = 3
) (
    input  logic       clk10hz,
    input  logic       nReset,
    input  logic [3:0] alarmHourTens,
    input  logic [3:0] alarmHourMu,
    input  logic [3:0] alarmMinTens,
    input  logic [3:0] alarmMinMu,
    input  logic [3:0] timeHourTens,
    input  logic [3:0] timeHourMu,
    input  logic [3:0] timeMinTens,
    input  logic [3:0] timeMinMu,
    input  logic [3:0] timeSecTens,
    input  logic [3:0] timeSecMu,
    input  logic       alarmEn,
    input  logic       snoozeBtn,
    input  logic       stopBtn,
    output logic       buzzer,
    output logic       ringing,
    output logic       snoozing,
    output logic [1:0] snoozesLeft
);

    localparam int RW = (RING_TICKS > 1) ? $clog2(RING_TICKS) : 1;
    localparam int SW = (SNOOZE_TICKS > 1) ? $clog2(SNOOZE_TICKS) : 1;
    localparam logic [1:0]    SNOOZE_INIT = 2'(MAX_SNOOZE);
    localparam logic [RW-1:0] RING_LAST   = RW'(RING_TICKS - 1);
    localparam logic [SW-1:0] SNOOZE_LAST = SW'(SNOOZE_TICKS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RING   = 2'b01,
        SNOOZE = 2'b10
    } stateType;

    stateType      state, stateNext;
    logic [RW-1:0] ringCnt, ringCntNext;
    logic [SW-1:0] snzCnt, snzCntNext;
    logic [1:0]    snoozesLeftNext;
    logic          matchPrev, snzPrev, stopPrev;
    logic          match, matchRise, snzRise, stopRise;

    // Alarm time is reached only at second zero of the programmed minute
    assign match = (timeHourTens == alarmHourTens) && (timeHourMu == alarmHourMu) &&
                   (timeMinTens == alarmMinTens) && (timeMinMu == alarmMinMu) &&
                   (timeSecTens == 4'd0) && (timeSecMu == 4'd0);

    assign matchRise = match & ~matchPrev;
    assign snzRise   = snoozeBtn & ~snzPrev;
    assign stopRise  = stopBtn & ~stopPrev;

    // Edge-detect history; cleared by reset so a match present at release counts as a rise
    always_ff @(posedge clk10hz or negedge nReset) begin
        if (!nReset) begin
            matchPrev <= 1'b0;
            snzPrev   <= 1'b0;
            stopPrev  <= 1'b0;
        end else begin
            matchPrev <= match;
            snzPrev   <= snoozeBtn;
            stopPrev  <= stopBtn;
        end
    end

    // State, counters and snooze budget registers
    always_ff @(posedge clk10hz or negedge nReset) begin
        if (!nReset) begin
            state       <= IDLE;
            ringCnt     <= '0;
            snzCnt      <= '0;
            snoozesLeft <= SNOOZE_INIT;
        end else begin
            state       <= stateNext;
            ringCnt     <= ringCntNext;
            snzCnt      <= snzCntNext;
            snoozesLeft <= snoozesLeftNext;
        end
    end

    // Next-state logic; each state lists its exits in priority order
    always_comb begin
        stateNext       = state;
        ringCntNext     = '0;
        snzCntNext      = '0;
        snoozesLeftNext = snoozesLeft;
        case (state)
            IDLE: begin
                if (alarmEn && matchRise) begin
                    stateNext       = RING;
                    snoozesLeftNext = SNOOZE_INIT;
                end
            end
            RING: begin
                if (!alarmEn || stopRise) begin
                    stateNext = IDLE;
                end else if (snzRise && (snoozesLeft != 2'd0)) begin
                    stateNext       = SNOOZE;
                    snoozesLeftNext = snoozesLeft - 2'd1;
                end else if (ringCnt == RING_LAST) begin
                    stateNext = IDLE;
                end else begin
                    ringCntNext = ringCnt + RW'(1);
                end
            end
            SNOOZE: begin
                if (!alarmEn || stopRise) begin
                    stateNext = IDLE;
                end else if (snzCnt == SNOOZE_LAST) begin
                    stateNext = RING;
                end else begin
                    snzCntNext = snzCnt + SW'(1);
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Status outputs and 1 Hz, 50 % beep that restarts with ringCnt on every RING entry
    always_comb begin
        ringing  = (state == RING);
        snoozing = (state == SNOOZE);
        buzzer   = (state == RING) && ((32'(ringCnt) % 32'd10) < 32'd5);
    end

endmodule

// File: tb/tb_alarm_trigger.sv
// tb/tb_alarm_trigger.sv - scoreboard bench for alarm_trigger
module tb_alarm_trigger;

    logic       clk10hz = 1'b0;
    logic       nReset;
    logic [3:0] alarmHourTens, alarmHourMu, alarmMinTens, alarmMinMu;
    logic [3:0] timeHourTens, timeHourMu, timeMinTens, timeMinMu, timeSecTens, timeSecMu;
    logic       alarmEn, snoozeBtn, stopBtn;
    logic       buzzer, ringing, snoozing;
    logic [1:0] snoozesLeft;

    typedef struct {
        string      tag;
        logic [4:0] exp;
    } sbItem;

    sbItem sbQ[$];
    int    checks   = 0;
    int    failures = 0;
    int    left;

    alarm_trigger #(
        .RING_TICKS  (600),
        .SNOOZE_TICKS(20),
        .MAX_SNOOZE  (3)
    ) dut (
        .clk10hz      (clk10hz),
        .nReset       (nReset),
        .alarmHourTens(alarmHourTens),
        .alarmHourMu  (alarmHourMu),
        .alarmMinTens (alarmMinTens),
        .alarmMinMu   (alarmMinMu),
        .timeHourTens (timeHourTens),
        .timeHourMu   (timeHourMu),
        .timeMinTens  (timeMinTens),
        .timeMinMu    (timeMinMu),
        .timeSecTens  (timeSecTens),
        .timeSecMu    (timeSecMu),
        .alarmEn      (alarmEn),
        .snoozeBtn    (snoozeBtn),
        .stopBtn      (stopBtn),
        .buzzer       (buzzer),
        .ringing      (ringing),
        .snoozing     (snoozing),
        .snoozesLeft  (snoozesLeft)
    );

    always #5 clk10hz = ~clk10hz;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Pops one expectation per clock, sampled 1 time unit after the rising edge
    always begin
        @(posedge clk10hz);
        #1;
        if (sbQ.size() > 0) begin
            sbItem it;
            it = sbQ.pop_front();
            checkEq(it.tag, 32'({ringing, snoozing, buzzer, snoozesLeft}), 32'(it.exp));
        end
    end

    task automatic setTime(input int h, input int m, input int s);
        timeHourTens = 4'(h / 10);
        timeHourMu   = 4'(h % 10);
        timeMinTens  = 4'(m / 10);
        timeMinMu    = 4'(m % 10);
        timeSecTens  = 4'(s / 10);
        timeSecMu    = 4'(s % 10);
    endtask

    // Queue the expected outputs after the coming edge, then advance past it
    task automatic cyc(input string tag, input logic r, input logic s, input logic b,
                       input logic [1:0] l);
        sbItem it;
        it.tag = tag;
        it.exp = {r, s, b, l};
        sbQ.push_back(it);
        @(posedge clk10hz);
        #2;
    endtask

    task automatic ringCyc(input string tag, input int k, input int l);
        cyc(tag, 1'b1, 1'b0, ((k % 10) < 5), 2'(l));
    endtask

    task automatic startRing();
        setTime(7, 29, 59);
        cyc("pre_match", 1'b0, 1'b0, 1'b0, 2'(left));
        setTime(7, 30, 0);
        left = 3;
        ringCyc("ring_entry", 0, left);
    endtask

    initial begin
        nReset = 1'b0;
        alarmHourTens = 4'd0; alarmHourMu = 4'd7; alarmMinTens = 4'd3; alarmMinMu = 4'd0;
        setTime(7, 29, 59);
        alarmEn = 1'b1; snoozeBtn = 1'b0; stopBtn = 1'b0;
        left = 3;
        #12;
        checkEq("rst_outputs", 32'({ringing, snoozing, buzzer}), 32'd0);
        checkEq("rst_left", 32'(snoozesLeft), 32'd3);
        @(posedge clk10hz);
        #2;
        nReset = 1'b1;
        cyc("idle", 1'b0, 1'b0, 1'b0, 2'd3);

        // Ring to timeout; match stays high afterwards and must not retrigger
        startRing();
        for (int k = 1; k < 600; k++) ringCyc("ring_beep", k, 3);
        for (int i = 0; i < 3; i++) cyc("timeout_idle", 1'b0, 1'b0, 1'b0, 2'd3);

        // Match rises while disarmed, then arming during the match must not ring
        setTime(7, 29, 59);
        alarmEn = 1'b0;
        cyc("disarmed_pre", 1'b0, 1'b0, 1'b0, 2'd3);
        setTime(7, 30, 0);
        for (int i = 0; i < 3; i++) cyc("disarmed_match", 1'b0, 1'b0, 1'b0, 2'd3);
        alarmEn = 1'b1;
        for (int i = 0; i < 3; i++) cyc("armed_late", 1'b0, 1'b0, 1'b0, 2'd3);

        // Four snooze presses: three accepted, the last ignored
        startRing();
        setTime(7, 31, 0);
        for (int p = 0; p < 4; p++) begin
            for (int k = (p == 0) ? 1 : 0; k < 10; k++) ringCyc("snz_ring", k, left);
            snoozeBtn = 1'b1;
            if (left > 0) begin
                left--;
                cyc("snz_enter", 1'b0, 1'b1, 1'b0, 2'(left));
                snoozeBtn = 1'b0;
                for (int i = 1; i < 20; i++) begin
                    if (i == 5) snoozeBtn = 1'b1;
                    cyc("snz_hold", 1'b0, 1'b1, 1'b0, 2'(left));
                    snoozeBtn = 1'b0;
                end
            end else begin
                ringCyc("snz_ignored", 10, 0);
                snoozeBtn = 1'b0;
                for (int k = 11; k < 20; k++) ringCyc("snz_ignored_ring", k, 0);
            end
        end
        stopBtn = 1'b1;
        cyc("stop_after_snz", 1'b0, 1'b0, 1'b0, 2'd0);
        stopBtn = 1'b0;
        for (int i = 0; i < 2; i++) cyc("left_hold", 1'b0, 1'b0, 1'b0, 2'd0);

        // Stop and snooze in the same cycle: stop wins
        startRing();
        for (int k = 1; k < 5; k++) ringCyc("both_ring", k, 3);
        snoozeBtn = 1'b1;
        stopBtn   = 1'b1;
        cyc("both_stop", 1'b0, 1'b0, 1'b0, 2'd3);
        snoozeBtn = 1'b0;
        stopBtn   = 1'b0;
        for (int i = 0; i < 3; i++) cyc("both_idle", 1'b0, 1'b0, 1'b0, 2'd3);

        // Asynchronous reset in the middle of a snooze
        startRing();
        for (int k = 1; k < 3; k++) ringCyc("ar_ring", k, 3);
        snoozeBtn = 1'b1;
        cyc("ar_snz", 1'b0, 1'b1, 1'b0, 2'd2);
        snoozeBtn = 1'b0;
        for (int i = 0; i < 3; i++) cyc("ar_snz_hold", 1'b0, 1'b1, 1'b0, 2'd2);
        #1;
        nReset = 1'b0;
        #1;
        checkEq("async_rst_outputs", 32'({ringing, snoozing, buzzer}), 32'd0);
        checkEq("async_rst_left", 32'(snoozesLeft), 32'd3);
        @(posedge clk10hz);
        #2;

        // Match already high at reset release counts as a rise
        setTime(7, 30, 0);
        nReset = 1'b1;
        ringCyc("post_rst_ring", 0, 3);
        for (int k = 1; k < 4; k++) ringCyc("post_rst_beep", k, 3);
        alarmEn = 1'b0;
        cyc("disarm_ring", 1'b0, 1'b0, 1'b0, 2'd3);

        @(posedge clk10hz);
        #3;
        checkEq("sb_drained", 32'(sbQ.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
